// File: rtl/sub_byte_combinational.sv
// AES forward S-box in logic: composite-field GF((2^4)^2) inverse plus affine, output registered (latency 1, no backpressure).
// Define SBOX_PIPE_EN to register after the GF(2^4) inversion stage (latency 2, still 1 byte/cycle).
module sub_byte_combinational (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);

  // GF(2^4), polynomial x^4 + x + 1
  function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] r;
    logic [3:0] t;
    r = 4'h0;
    t = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) r = r ^ t;
      t = {t[2:0], 1'b0} ^ (t[3] ? 4'h3 : 4'h0);
    end
    return r;
  endfunction

  function automatic logic [3:0] gf16_sq(input logic [3:0] a);
    return {a[3], a[1] ^ a[3], a[2], a[0] ^ a[2]};
  endfunction

  function automatic logic [3:0] gf16_mul_lambda(input logic [3:0] a);
    return gf16_mul(a, 4'hC);
  endfunction

  function automatic logic [3:0] gf16_inv(input logic [3:0] a);
    logic [3:0] r;
    case (a)
      4'h0: r = 4'h0;  4'h1: r = 4'h1;  4'h2: r = 4'h9;  4'h3: r = 4'hE;
      4'h4: r = 4'hD;  4'h5: r = 4'hB;  4'h6: r = 4'h7;  4'h7: r = 4'h6;
      4'h8: r = 4'hF;  4'h9: r = 4'h2;  4'hA: r = 4'hC;  4'hB: r = 4'h5;
      4'hC: r = 4'hA;  4'hD: r = 4'h4;  4'hE: r = 4'h3;  default: r = 4'h8;
    endcase
    return r;
  endfunction

  // Composite element packed as {high, low}, extension y^2 = y + lambda
  function automatic logic [7:0] gfc_mul(input logic [7:0] a, input logic [7:0] b);
    logic [3:0] hh;
    hh = gf16_mul(a[7:4], b[7:4]);
    return {hh ^ gf16_mul(a[7:4], b[3:0]) ^ gf16_mul(a[3:0], b[7:4]),
            gf16_mul_lambda(hh) ^ gf16_mul(a[3:0], b[3:0])};
  endfunction

  function automatic logic [7:0] gfc_inv(input logic [7:0] a);
    logic [3:0] ah;
    logic [3:0] al;
    logic [3:0] d;
    logic [3:0] di;
    ah = a[7:4];
    al = a[3:0];
    d  = gf16_mul_lambda(gf16_sq(ah)) ^ gf16_mul(ah, al) ^ gf16_sq(al);
    di = gf16_inv(d);
    return {gf16_mul(ah, di), gf16_mul(ah ^ al, di)};
  endfunction

  // Column i of a matrix lives at m[8*i +: 8]
  function automatic logic [7:0] mat_apply(input logic [63:0] m, input logic [7:0] x);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++)
      if (x[i]) r = r ^ m[8*i +: 8];
    return r;
  endfunction

  // Elaboration only: a root of x^8+x^4+x^3+x+1 in the composite field fixes the isomorphism
  function automatic logic [7:0] find_root();
    logic [7:0] b;
    logic [7:0] b2;
    logic [7:0] b4;
    logic [7:0] b8;
    logic [7:0] root;
    logic       found;
    root  = 8'h00;
    found = 1'b0;
    for (int c = 2; c < 256; c++) begin
      b  = c[7:0];
      b2 = gfc_mul(b, b);
      b4 = gfc_mul(b2, b2);
      b8 = gfc_mul(b4, b4);
      if (!found && ((b8 ^ b4 ^ gfc_mul(b2, b) ^ b ^ 8'h01) == 8'h00)) begin
        root  = b;
        found = 1'b1;
      end
    end
    return root;
  endfunction

  function automatic logic [63:0] build_iso();
    logic [63:0] m;
    logic [7:0]  beta;
    logic [7:0]  p;
    beta = find_root();
    p    = 8'h01;
    m    = 64'h0;
    for (int i = 0; i < 8; i++) begin
      m[8*i +: 8] = p;
      p = gfc_mul(p, beta);
    end
    return m;
  endfunction

  function automatic logic [63:0] build_inv(input logic [63:0] m);
    logic [63:0] r;
    logic [7:0]  y;
    r = 64'h0;
    for (int x = 0; x < 256; x++) begin
      y = mat_apply(m, x[7:0]);
      for (int j = 0; j < 8; j++)
        if (y == (8'h01 << j)) r[8*j +: 8] = x[7:0];
    end
    return r;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  localparam logic [63:0] ISO_M = build_iso();
  localparam logic [63:0] INV_M = build_inv(ISO_M);

  logic [7:0] comp_in;
  logic [7:0] comp_inv;
  logic [7:0] stage;
  logic [7:0] data_d;
  logic [7:0] data_q;

  always_comb begin
    comp_in  = mat_apply(ISO_M, data_in);
    comp_inv = gfc_inv(comp_in);
  end

`ifdef SBOX_PIPE_EN
  logic [7:0] inv_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) inv_q <= 8'h00;
    else     inv_q <= comp_inv;
  end

  assign stage = inv_q;
`else
  assign stage = comp_inv;
`endif

  always_comb data_d = affine(mat_apply(INV_M, stage));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) data_q <= 8'h00;
    else     data_q <= data_d;
  end

  assign data_out = data_q;

endmodule

// File: tb/tb_sub_byte_combinational.sv
// Scoreboard bench for sub_byte_combinational against a GF(2^8) reference (brute-force inverse + rotate affine).
module tb_sub_byte_combinational;

`ifdef SBOX_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   data_in;
  logic [7:0]   data_out;
  logic [127:0] par_in;
  logic [127:0] par_out;
  logic         stim_vld;
  logic [1:0]   vp;
  logic [7:0]   exp_q[$];
  int           total = 0;
  int           bad   = 0;

  always #5 clk = ~clk;

  sub_byte_combinational dut (
    .clk     (clk),
    .rst     (rst),
    .data_in (data_in),
    .data_out(data_out)
  );

  for (genvar g = 0; g < 16; g++) begin : g_par
    sub_byte_combinational u_par (
      .clk     (clk),
      .rst     (rst),
      .data_in (par_in[8*g +: 8]),
      .data_out(par_out[8*g +: 8])
    );
  end

  function automatic logic [7:0] gmul8(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] t;
    r = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1B : 8'h00);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox_model(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] b;
    inv = 8'h00;
    for (int y = 1; y < 256; y++)
      if (gmul8(x, y[7:0]) == 8'h01) inv = y[7:0];
    b = inv;
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [7:0] b, input logic v, input logic [7:0] e);
    @(posedge clk);
    #1;
    data_in  = b;
    stim_vld = v;
    if (v) exp_q.push_back(e);
  endtask

  // Marks which cycles carry a byte the scoreboard expects back, LAT edges later
  always @(posedge clk or posedge rst) begin
    if (rst) vp <= 2'b00;
    else     vp <= {vp[0], stim_vld};
  end

  always @(negedge clk) begin
    if (!rst && vp[LAT-1]) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_underflow: actual=%0h required=<queued entry> @%0t", data_out, $time);
      end else begin
        check("sb", {120'h0, data_out}, {120'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  logic [15:0] known [10] = '{16'h0063, 16'h017C, 16'h53ED, 16'hFF16, 16'h19D4,
                              16'hA0E0, 16'h9AB8, 16'hE91E, 16'hC9DD, 16'h10CA};

  initial begin
    logic [7:0]   r;
    logic [127:0] pv;
    logic [127:0] pe;
    rst      = 1'b0;
    data_in  = 8'h00;
    stim_vld = 1'b0;
    par_in   = '0;

    #2;
    data_in = 8'h53;
    rst     = 1'b1;
    #1;
    check("rst_async", {120'h0, data_out}, 128'h0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold", {120'h0, data_out}, 128'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_release_1", {120'h0, data_out}, {120'h0, (LAT == 1) ? 8'hED : 8'h63});
    @(posedge clk);
    #1;
    check("rst_release_2", {120'h0, data_out}, 128'hED);

    for (int i = 0; i < 10; i++) drive(known[i][15:8], 1'b1, known[i][7:0]);

    for (int i = 0; i < 256; i++) drive(i[7:0], 1'b1, sbox_model(i[7:0]));

    for (int i = 0; i < 200; i++) begin
      r = 8'($urandom_range(0, 255));
      drive(r, 1'b1, sbox_model(r));
    end

    for (int i = 0; i < 256; i++) begin
      drive(i[7:0], 1'b1, sbox_model(i[7:0]));
      if (i == 100) begin
        #2;
        rst      = 1'b1;
        stim_vld = 1'b0;
        exp_q.delete();
        #1;
        check("rst_midstream", {120'h0, data_out}, 128'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("after_mid_rst", {120'h0, data_out},
              {120'h0, (LAT == 1) ? sbox_model(data_in) : 8'h63});
      end
    end

    @(posedge clk);
    #1;
    stim_vld = 1'b0;
    repeat (LAT + 2) @(posedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: actual=%0d left required=0", exp_q.size());
    end

    par_in = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    repeat (LAT) @(posedge clk);
    #1;
    check("parallel_vec", par_out, 128'hd42711aee0bf98f1b8b45de51e415230);

    for (int k = 0; k < 3; k++) begin
      for (int b = 0; b < 16; b++) begin
        pv[8*b +: 8] = 8'($urandom_range(0, 255));
        pe[8*b +: 8] = sbox_model(pv[8*b +: 8]);
      end
      par_in = pv;
      repeat (LAT) @(posedge clk);
      #1;
      check("parallel_rand", par_out, pe);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
